// File: rtl/alu_seq_pkg.sv
// Shared opcodes, ALU codes, FSM state encoding and IR field positions for the ALU op sequencer.
// Latency: none (declarations only).
// Backpressure: none.
package alu_seq_pkg;

   localparam logic [4:0] OP_ADD = 5'b00000;
   localparam logic [4:0] OP_SUB = 5'b00001;
   localparam logic [4:0] OP_MUL = 5'b00010;
   localparam logic [4:0] OP_DIV = 5'b00011;
   localparam logic [4:0] OP_AND = 5'b00100;
   localparam logic [4:0] OP_OR  = 5'b00101;
   localparam logic [4:0] OP_SHR = 5'b00110;
   localparam logic [4:0] OP_SHL = 5'b00111;
   localparam logic [4:0] OP_ROR = 5'b01000;
   localparam logic [4:0] OP_ROL = 5'b01001;
   localparam logic [4:0] OP_NEG = 5'b01010;
   localparam logic [4:0] OP_NOT = 5'b01011;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_MUL = 4'b0010;
   localparam logic [3:0] ALU_DIV = 4'b0011;
   localparam logic [3:0] ALU_AND = 4'b0100;
   localparam logic [3:0] ALU_OR  = 4'b0101;
   localparam logic [3:0] ALU_SHR = 4'b0110;
   localparam logic [3:0] ALU_SHL = 4'b0111;
   localparam logic [3:0] ALU_ROR = 4'b1000;
   localparam logic [3:0] ALU_ROL = 4'b1001;
   localparam logic [3:0] ALU_NEG = 4'b1010;
   localparam logic [3:0] ALU_NOT = 4'b1011;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_T0    = 4'd1,
      S_T1    = 4'd2,
      S_T2    = 4'd3,
      S_T3    = 4'd4,
      S_T4    = 4'd5,
      S_T5    = 4'd6,
      S_T6    = 4'd7,
      S_FAULT = 4'd8
   } state_t;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int RA_MSB  = 26;
   localparam int RA_LSB  = 23;
   localparam int RB_MSB  = 22;
   localparam int RB_LSB  = 19;
   localparam int RC_MSB  = 18;
   localparam int RC_LSB  = 15;

   function automatic logic [15:0] onehot16(input logic [3:0] idx);
      return 16'(1) << idx;
   endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational IR decode into register fields, ALU code, MUL/DIV flag and legality; MUL/DIV legal only with MULDIV_EN.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module alu_seq_decode
   import alu_seq_pkg::*;
(
   input  logic [31:0] ir,
   output logic [3:0]  ra,
   output logic [3:0]  rb,
   output logic [3:0]  rc,
   output logic [3:0]  operation,
   output logic        is_muldiv,
   output logic        legal
);

   logic [4:0] opcode;
   logic       unused_ir_bits;

   assign opcode         = ir[OPC_MSB:OPC_LSB];
   assign ra             = ir[RA_MSB:RA_LSB];
   assign rb             = ir[RB_MSB:RB_LSB];
   assign rc             = ir[RC_MSB:RC_LSB];
   assign unused_ir_bits = ^ir[RC_LSB-1:0];

   always_comb begin
      operation = ALU_ADD;
      is_muldiv = 1'b0;
      legal     = 1'b1;
      case (opcode)
         OP_ADD: operation = ALU_ADD;
         OP_SUB: operation = ALU_SUB;
         OP_AND: operation = ALU_AND;
         OP_OR:  operation = ALU_OR;
         OP_SHR: operation = ALU_SHR;
         OP_SHL: operation = ALU_SHL;
         OP_ROR: operation = ALU_ROR;
         OP_ROL: operation = ALU_ROL;
         OP_NEG: operation = ALU_NEG;
         OP_NOT: operation = ALU_NOT;
`ifdef MULDIV_EN
         OP_MUL: begin
            operation = ALU_MUL;
            is_muldiv = 1'b1;
         end
         OP_DIV: begin
            operation = ALU_DIV;
            is_muldiv = 1'b1;
         end
`endif
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Moore control sequencer stepping DataPath strobes through T0..T6 for reg-reg ALU ops; MULDIV_EN adds the MUL/DIV LO/HI path.
// Latency: 6 cycles ALU op, 7 cycles MUL/DIV, plus one cycle per mem_rdy-low cycle in T1.
// Backpressure: holds in T1 until mem_rdy; run is only sampled in IDLE.
module alu_op_sequencer
   import alu_seq_pkg::*;
(
   input  logic        Clock,
   input  logic        clear,
   input  logic        run,
   input  logic [31:0] IR,
   input  logic        mem_rdy,
   output logic        PCout,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        MDRout,
   output logic        MARin,
   output logic        PCin,
   output logic        MDRin,
   output logic        IRin,
   output logic        Yin,
   output logic        HIin,
   output logic        LOin,
   output logic        Zin_low,
   output logic        Zin_high,
   output logic        IncPC,
   output logic        Read,
   output logic [15:0] Rout_sel,
   output logic [15:0] Rin_sel,
   output logic [3:0]  operation,
   output logic        busy,
   output logic        done,
   output logic        fault
);

   state_t     state, next_state;
   logic       t1_first;
   logic [3:0] ra, rb, rc, dec_op;
   logic       is_muldiv, legal;

   alu_seq_decode u_decode (
      .ir        (IR),
      .ra        (ra),
      .rb        (rb),
      .rc        (rc),
      .operation (dec_op),
      .is_muldiv (is_muldiv),
      .legal     (legal)
   );

   // t1_first marks the first T1 cycle so the PC reloads only once during a stall
   always_ff @(posedge Clock) begin
      if (clear) begin
         state    <= S_IDLE;
         t1_first <= 1'b0;
      end else begin
         state    <= next_state;
         t1_first <= (state == S_T0);
      end
   end

   always_comb begin
      next_state = state;
      PCout      = 1'b0;
      Zlowout    = 1'b0;
      Zhighout   = 1'b0;
      MDRout     = 1'b0;
      MARin      = 1'b0;
      PCin       = 1'b0;
      MDRin      = 1'b0;
      IRin       = 1'b0;
      Yin        = 1'b0;
      HIin       = 1'b0;
      LOin       = 1'b0;
      Zin_low    = 1'b0;
      Zin_high   = 1'b0;
      IncPC      = 1'b0;
      Read       = 1'b0;
      Rout_sel   = 16'h0000;
      Rin_sel    = 16'h0000;
      operation  = 4'b0000;
      busy       = (state != S_IDLE) && (state != S_FAULT);
      done       = 1'b0;
      fault      = 1'b0;
      case (state)
         S_IDLE: if (run) next_state = S_T0;
         S_T0: begin
            PCout      = 1'b1;
            MARin      = 1'b1;
            IncPC      = 1'b1;
            Zin_low    = 1'b1;
            Zin_high   = 1'b1;
            next_state = S_T1;
         end
         S_T1: begin
            Zlowout = 1'b1;
            PCin    = t1_first;
            Read    = 1'b1;
            MDRin   = 1'b1;
            if (mem_rdy) next_state = S_T2;
         end
         S_T2: begin
            MDRout     = 1'b1;
            IRin       = 1'b1;
            next_state = S_T3;
         end
         S_T3: begin
            if (!legal) begin
               next_state = S_FAULT;
            end else begin
               Yin        = 1'b1;
               Rout_sel   = onehot16(is_muldiv ? ra : rb);
               next_state = S_T4;
            end
         end
         S_T4: begin
            Rout_sel   = onehot16(is_muldiv ? rb : rc);
            operation  = dec_op;
            Zin_low    = 1'b1;
            Zin_high   = 1'b1;
            next_state = S_T5;
         end
         S_T5: begin
            Zlowout = 1'b1;
`ifdef MULDIV_EN
            if (is_muldiv) begin
               LOin       = 1'b1;
               next_state = S_T6;
            end else
`endif
            begin
               Rin_sel    = onehot16(ra);
               done       = 1'b1;
               next_state = S_IDLE;
            end
         end
`ifdef MULDIV_EN
         S_T6: begin
            Zhighout   = 1'b1;
            HIin       = 1'b1;
            done       = 1'b1;
            next_state = S_IDLE;
         end
`endif
         S_FAULT: fault = 1'b1;
         default: next_state = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: expected control words are queued per instruction and compared each cycle.
// MULDIV_EN selects whether the DIV scenario expects LO/HI writeback or a fault.
module tb_alu_op_sequencer;

   typedef struct packed {
      logic        pcout, zlowout, zhighout, mdrout, marin, pcin, mdrin, irin;
      logic        yin, hiin, loin, zinl, zinh, incpc, read;
      logic [15:0] rout, rin;
      logic [3:0]  op;
      logic        busy, done, fault;
   } ctl_t;

   logic        Clock, clear, run, mem_rdy;
   logic [31:0] IR;
   logic        PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin;
   logic        Yin, HIin, LOin, Zin_low, Zin_high, IncPC, Read;
   logic [15:0] Rout_sel, Rin_sel;
   logic [3:0]  operation;
   logic        busy, done, fault;

   ctl_t obs;
   ctl_t exp_q[$];
   ctl_t zero_w;
   int   checks = 0;
   int   failures = 0;

   alu_op_sequencer dut (
      .Clock(Clock), .clear(clear), .run(run), .IR(IR), .mem_rdy(mem_rdy),
      .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
      .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
      .HIin(HIin), .LOin(LOin), .Zin_low(Zin_low), .Zin_high(Zin_high),
      .IncPC(IncPC), .Read(Read), .Rout_sel(Rout_sel), .Rin_sel(Rin_sel),
      .operation(operation), .busy(busy), .done(done), .fault(fault)
   );

   assign obs = {PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin,
                 Yin, HIin, LOin, Zin_low, Zin_high, IncPC, Read,
                 Rout_sel, Rin_sel, operation, busy, done, fault};

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "bench did not finish");
   end

   function automatic logic [31:0] mk_ir(logic [4:0] opc, logic [3:0] ra, logic [3:0] rb, logic [3:0] rc);
      return {opc, ra, rb, rc, 15'd0};
   endfunction

   function automatic logic [15:0] bit16(int i);
      logic [15:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic push_fetch(int stalls);
      ctl_t w;
      w = '0; w.busy = 1; w.pcout = 1; w.marin = 1; w.incpc = 1; w.zinl = 1; w.zinh = 1;
      exp_q.push_back(w);
      for (int j = 0; j <= stalls; j++) begin
         w = '0; w.busy = 1; w.zlowout = 1; w.pcin = (j == 0); w.read = 1; w.mdrin = 1;
         exp_q.push_back(w);
      end
      w = '0; w.busy = 1; w.mdrout = 1; w.irin = 1;
      exp_q.push_back(w);
   endtask

   task automatic push_alu(int ra, int rb, int rc, logic [3:0] op, int stalls);
      ctl_t w;
      push_fetch(stalls);
      w = '0; w.busy = 1; w.rout = bit16(rb); w.yin = 1;
      exp_q.push_back(w);
      w = '0; w.busy = 1; w.rout = bit16(rc); w.op = op; w.zinl = 1; w.zinh = 1;
      exp_q.push_back(w);
      w = '0; w.busy = 1; w.zlowout = 1; w.rin = bit16(ra); w.done = 1;
      exp_q.push_back(w);
      exp_q.push_back(zero_w);
   endtask

   task automatic push_muldiv(int ra, int rb, logic [3:0] op);
      ctl_t w;
      push_fetch(0);
      w = '0; w.busy = 1; w.rout = bit16(ra); w.yin = 1;
      exp_q.push_back(w);
      w = '0; w.busy = 1; w.rout = bit16(rb); w.op = op; w.zinl = 1; w.zinh = 1;
      exp_q.push_back(w);
      w = '0; w.busy = 1; w.zlowout = 1; w.loin = 1;
      exp_q.push_back(w);
      w = '0; w.busy = 1; w.zhighout = 1; w.hiin = 1; w.done = 1;
      exp_q.push_back(w);
      exp_q.push_back(zero_w);
   endtask

   task automatic push_fault(int nfault);
      ctl_t w;
      push_fetch(0);
      w = '0; w.busy = 1;
      exp_q.push_back(w);
      for (int k = 0; k < nfault; k++) begin
         w = '0; w.fault = 1;
         exp_q.push_back(w);
      end
   endtask

   // Starts at a negedge in IDLE; drains the queue one control word per cycle
   task automatic play(string name, logic [31:0] ir, bit hold_run, int stalls, int busy_exp);
      int   cyc;
      int   busy_n;
      ctl_t e;
      cyc = 0;
      busy_n = 0;
      IR = ir;
      run = 1'b1;
      mem_rdy = 1'b1;
      @(posedge Clock);
      while (exp_q.size() > 0) begin
         @(negedge Clock);
         e = exp_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, obs, e);
         end
         if (obs.busy === 1'b1) busy_n++;
         if (!hold_run) run = 1'b0;
         mem_rdy = (cyc == 0) ? 1'b1 : ((cyc - 1) >= stalls);
         cyc++;
      end
      if (busy_exp > 0) begin
         checks++;
         if (busy_n !== busy_exp) begin
            failures++;
            $display("FAIL %s_busy_cycles got=%0d expected=%0d", name, busy_n, busy_exp);
         end
      end
   endtask

   task automatic do_clear(string name);
      run = 1'b0;
      clear = 1'b1;
      @(posedge Clock);
      @(negedge Clock);
      checks++;
      if (obs !== zero_w) begin
         failures++;
         $display("FAIL %s_clear got=%h expected=%h", name, obs, zero_w);
      end
      clear = 1'b0;
      @(negedge Clock);
      checks++;
      if (obs !== zero_w) begin
         failures++;
         $display("FAIL %s_after_clear got=%h expected=%h", name, obs, zero_w);
      end
   endtask

   task automatic test_reset();
      ctl_t w;
      clear = 1'b1; run = 1'b0; mem_rdy = 1'b1; IR = '0;
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      checks++;
      if (obs !== zero_w) begin
         failures++;
         $display("FAIL reset_state got=%h expected=%h", obs, zero_w);
      end
      clear = 1'b0;
      @(negedge Clock);
      // abort an ADD in T4
      push_fetch(0);
      w = '0; w.busy = 1; w.rout = 16'h0002; w.yin = 1;
      exp_q.push_back(w);
      play("reset_pre", 32'h0088_8000, 1'b0, 0, -1);
      @(negedge Clock);
      checks++;
      if (obs.zinl !== 1'b1 || obs.rout !== 16'h0002 || obs.busy !== 1'b1) begin
         failures++;
         $display("FAIL reset_in_t4 got=%h expected zinl=1 rout=0002 busy=1", obs);
      end
      clear = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(posedge Clock);
         @(negedge Clock);
         checks++;
         if (obs !== zero_w) begin
            failures++;
            $display("FAIL reset_mid_t4 cycle=%0d got=%h expected=%h", k, obs, zero_w);
         end
      end
      clear = 1'b0;
      @(negedge Clock);
      checks++;
      if (obs !== zero_w) begin
         failures++;
         $display("FAIL reset_release got=%h expected=%h", obs, zero_w);
      end
   endtask

   task automatic test_add();
      push_alu(1, 1, 1, 4'b0000, 0);
      play("add", 32'h0088_8000, 1'b0, 0, 6);
   endtask

   task automatic test_alu_patterns();
      push_alu(3, 5, 9, 4'b0001, 0);
      play("sub", mk_ir(5'b00001, 4'd3, 4'd5, 4'd9), 1'b0, 0, 6);
      push_alu(2, 4, 0, 4'b1011, 0);
      play("not", mk_ir(5'b01011, 4'd2, 4'd4, 4'd0), 1'b0, 0, 6);
      push_alu(15, 0, 14, 4'b1001, 0);
      play("rol", mk_ir(5'b01001, 4'd15, 4'd0, 4'd14), 1'b0, 0, 6);
   endtask

   task automatic test_mem_stall();
      push_alu(1, 1, 1, 4'b0000, 3);
      play("stall", 32'h0088_8000, 1'b0, 3, 9);
   endtask

   task automatic test_muldiv();
`ifdef MULDIV_EN
      push_muldiv(6, 7, 4'b0011);
      play("div", 32'h1B38_0000, 1'b0, 0, 7);
`else
      push_fault(3);
      play("div_illegal", 32'h1B38_0000, 1'b1, 0, 4);
      do_clear("div_illegal");
`endif
   endtask

   task automatic test_illegal();
      push_fault(4);
      play("illegal", 32'hF800_0000, 1'b1, 0, 4);
      do_clear("illegal");
      push_fault(2);
      play("illegal_0c", mk_ir(5'b01100, 4'd1, 4'd2, 4'd3), 1'b0, 0, 4);
      do_clear("illegal_0c");
   endtask

   task automatic test_back_to_back();
      ctl_t w;
      push_alu(3, 5, 9, 4'b0001, 0);
      w = '0; w.busy = 1; w.pcout = 1; w.marin = 1; w.incpc = 1; w.zinl = 1; w.zinh = 1;
      exp_q.push_back(w);
      play("b2b", mk_ir(5'b00001, 4'd3, 4'd5, 4'd9), 1'b1, 0, 7);
      do_clear("b2b");
   endtask

   initial begin
      zero_w = '0;
      test_reset();
      test_add();
      test_alu_patterns();
      test_mem_stall();
      test_muldiv();
      test_illegal();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Hardwired control sequencer that drives the DataPath's bus-select, register-enable, memory and ALU control lines through the T0–T6 fetch/execute steps for register-register ALU instructions. It replaces hand-timed testbench strobes with a clocked Moore FSM. Each instruction fetch waits on a memory-ready handshake. The sequencer sits between the IR output of DataPath and its control inputs, one control word per clock.

## Interface
- No parameters. Opcode and ALU codes come from the shared package.
- Clock  in  1  system clock, rising-edge active
- clear  in  1  synchronous, active-high reset
- run  in  1  start request, sampled in IDLE
- IR  in  32  DataPath IR contents
- mem_rdy  in  1  memory data valid for the Read in T1
- PCout, Zlowout, Zhighout, MDRout  out  1 each  bus drive selects
- MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zin_low, Zin_high  out  1 each  register load enables
- IncPC, Read  out  1 each  PC-increment and memory-read strobes
- Rout_sel  out  16  one-hot GP register bus drive (R0out..R15out)
- Rin_sel  out  16  one-hot GP register load (R0in..R15in)
- operation  out  4  ALU operation code
- busy  out  1  high in T0..T6
- done  out  1  one-cycle pulse in the final T state of an instruction
- fault  out  1  sticky illegal-opcode flag

## Operation
- IR fields: opcode=IR[31:27], Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15].
- Opcode → operation: ADD 00000→0000, SUB 00001→0001, MUL 00010→0010, DIV 00011→0011, AND 00100→0100, OR 00101→0101, SHR 00110→0110, SHL 00111→0111, ROR 01000→1000, ROL 01001→1001, NEG 01010→1010, NOT 01011→1011. All other opcodes are illegal.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, FAULT.
- IDLE: all outputs 0. If run=1, go to T0.
- T0: PCout, MARin, IncPC, Zin_low, Zin_high.
- T1: Zlowout, PCin, Read, MDRin. Hold T1 while mem_rdy=0. PCin is asserted only in the first T1 cycle, so the PC is loaded once. Go to T2 when mem_rdy=1.
- T2: MDRout, IRin.
- T3: decode IR. Illegal opcode: no strobes, go to FAULT. Legal opcode: Rout_sel[Rb], Yin. For MUL/DIV: Rout_sel[Ra], Yin.
- T4: Rout_sel[Rc] (MUL/DIV: Rout_sel[Rb]), operation=decoded code, Zin_low, Zin_high.
- T5, ALU ops: Zlowout, Rin_sel[Ra], done; then go to IDLE.
- T5, MUL/DIV: Zlowout, LOin.
- T6, MUL/DIV only: Zhighout, HIin, done; then go to IDLE.
- Unary NEG/NOT use the normal flow; the ALU ignores Y.
- FAULT: fault=1, all other outputs 0, run ignored. Only clear exits FAULT.
- operation is 0000 in every state except T4.

## Timing
- Outputs are decoded combinationally from the registered state and IR only. They are Moore outputs, with no combinational path from run or mem_rdy to any output.
- clear asserted at an edge puts the FSM in IDLE and clears fault. Every output reads 0 from that edge on. clear mid-instruction aborts it with no done pulse.
- Latency with mem_rdy tied high: ALU op is 6 cycles T0..T5. MUL/DIV is 7 cycles T0..T6. Each mem_rdy=0 cycle in T1 adds one cycle.
- After done there is always at least one IDLE cycle. With run held high, the next T0 follows that single IDLE cycle.
- IR is sampled live in T3..T6. DataPath IR is stable from the end of T2 until the next T2.
- run deasserting during an instruction has no effect; the instruction completes.

## Configuration
- MULDIV_EN defined: MUL/DIV are legal and use the T5 LO / T6 HI writeback; T6 exists.
- MULDIV_EN undefined: opcodes 00010 and 00011 are illegal and go T3→FAULT; the T6 state and the HIin/Zhighout drive logic are removed. The HIin, LOin and Zhighout ports remain and are tied 0.

## Structure
- Package alu_seq_pkg holds:
  - the opcode localparams;
  - the ALU operation codes;
  - the state encoding (4-bit, IDLE=0);
  - the IR field bit positions.
- Sub-module alu_seq_decode: combinational IR → {Ra, Rb, Rc, operation, is_muldiv, legal}, honouring MULDIV_EN.
- Top level holds the state register, next-state logic and output decode.

## Test plan
- Reset: drive clear high for 2 cycles mid-T4 → IDLE; all outputs 0; no done pulse.
- ADD with IR=0x00888000 (Ra=1, Rb=1, Rc=1), mem_rdy=1, run pulse:
  - T3: Rout_sel=0x0002 and Yin;
  - T4: operation=0000, Zin_low and Zin_high;
  - T5: Rin_sel=0x0002 and done;
  - busy is high for exactly 6 cycles.
- DIV with IR=0x1B380000 (Ra=R6, Rb=R7), MULDIV_EN defined:
  - T3: Rout_sel=0x0040;
  - T4: Rout_sel=0x0080 and operation=0011;
  - T5: LOin;
  - T6: HIin and done.
- mem_rdy held low for 3 cycles in T1:
  - T1 lasts 4 cycles;
  - PCin is high only in the first T1 cycle;
  - total latency is 9 cycles.
- Illegal opcode IR=0xF8000000:
  - fault=1 from the T3+1 edge onward;
  - run is ignored;
  - clear returns fault to 0.
- MULDIV_EN undefined with IR=0x1B380000 → FAULT after T3; LOin and HIin are never asserted.
